// File: rtl/audio_pkg.sv
// Shared audio definitions for the I2S serializer, the waveform generator and
// the codec configuration block.
//   DATA_W        : sample width in bits
//   sample_t      : signed sample type
//   BCLK_HALF_DEF : default clk_50m cycles per BCLK half-period
//   SLOT_BITS_DEF : default BCLK periods per channel slot
package audio_pkg;

    localparam int DATA_W        = 16;
    localparam int BCLK_HALF_DEF = 8;
    localparam int SLOT_BITS_DEF = 32;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider for the I2S transmitter. bclk toggles every BCLK_HALF cycles of
// clk_50m. The strobes are high in the cycle whose closing edge makes bclk
// rise or fall, so the caller can update state on that same edge.
//   clk_50m  : system clock
//   rst      : synchronous, active-high reset
//   bclk     : bit clock, 0 after reset
//   rise_evt : bclk goes 0->1 at the next edge
//   fall_evt : bclk goes 1->0 at the next edge
module i2s_bclk_gen
    import audio_pkg::*;
#(
    parameter int BCLK_HALF = BCLK_HALF_DEF
)(
    input  logic clk_50m,
    input  logic rst,
    output logic bclk,
    output logic rise_evt,
    output logic fall_evt
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             at_last;

    assign at_last  = (div_cnt == DIV_LAST);
    assign rise_evt = at_last & ~bclk;
    assign fall_evt = at_last & bclk;

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (at_last) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// Master-mode I2S transmitter for the WM8731 DAC. Takes mono samples over
// valid/ready into a one-entry holding register and sends each frame's sample
// on both the left and right slots, MSB first, one BCLK after the LRCK edge.
//   clk_50m      : system clock
//   rst          : synchronous, active-high reset
//   s_data       : sample from the waveform generator
//   s_valid      : s_data valid
//   s_ready      : holding register empty
//   bclk         : bit clock (AUD_BCLK)
//   lrck         : 0 = left slot, 1 = right slot (AUD_DACLRCK / AUD_ADCLRCK)
//   dacdat       : serial data (AUD_DACDAT)
//   cur_sample   : sample carried by the current frame
//   underrun     : one-cycle pulse when a frame starts with no new sample
//   underrun_cnt : saturating underrun count, present only when
//                  I2S_UNDERRUN_CNT_EN is defined
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int DATA_W        = audio_pkg::DATA_W,
    parameter int BCLK_HALF     = BCLK_HALF_DEF,
    parameter int SLOT_BITS     = SLOT_BITS_DEF,
    parameter int UNDERRUN_HOLD = 1
)(
    input  logic              clk_50m,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bclk,
    output logic              lrck,
    output logic              dacdat,
    output logic [DATA_W-1:0] cur_sample,
    output logic              underrun
`ifdef I2S_UNDERRUN_CNT_EN
   ,output logic [15:0]       underrun_cnt
`endif
);

    localparam int CNT_W = $clog2(2 * SLOT_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_L   = CNT_W'(SLOT_BITS);

    logic              fall_evt;
    logic              rise_unused;   // data launches on falling edges only
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  pos;
    logic              bit_next;
    logic              frame_start;
    logic              hold_full;
    logic [DATA_W-1:0] hold_data;
    logic              xfer;

    i2s_bclk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_bclk_gen (
        .clk_50m  (clk_50m),
        .rst      (rst),
        .bclk     (bclk),
        .rise_evt (rise_unused),
        .fall_evt (fall_evt)
    );

    assign s_ready = ~hold_full;
    assign xfer    = s_valid & ~hold_full;

    always_comb begin
        cnt_next    = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
        pos         = (cnt_next >= SLOT_L) ? cnt_next - SLOT_L : cnt_next;
        frame_start = fall_evt && (cnt_next == '0);
        // pos 0 is the I2S delay bit; pos 1..DATA_W carry the sample MSB first
        bit_next    = 1'b0;
        for (int i = 1; i <= DATA_W; i++) begin
            if (pos == CNT_W'(i)) bit_next = cur_sample[DATA_W-i];
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            bit_cnt    <= CNT_LAST;
            lrck       <= 1'b0;
            dacdat     <= 1'b0;
            cur_sample <= '0;
            underrun   <= 1'b0;
            hold_full  <= 1'b0;
            hold_data  <= '0;
        end else begin
            underrun <= 1'b0;
            if (fall_evt) begin
                bit_cnt <= cnt_next;
                dacdat  <= bit_next;
                if (cnt_next == '0)
                    lrck <= 1'b0;
                else if (cnt_next == SLOT_L)
                    lrck <= 1'b1;
                if (frame_start) begin
                    if (hold_full) begin
                        cur_sample <= hold_data;
                    end else begin
                        underrun <= 1'b1;
                        if (UNDERRUN_HOLD == 0) cur_sample <= '0;
                    end
                end
            end
            // A sample arriving on an underrunning frame start is kept for
            // the next frame; the current frame is never touched.
            if (frame_start && hold_full) begin
                hold_full <= 1'b0;
            end else if (xfer) begin
                hold_full <= 1'b1;
                hold_data <= s_data;
            end
        end
    end

`ifdef I2S_UNDERRUN_CNT_EN
    always_ff @(posedge clk_50m) begin
        if (rst)
            underrun_cnt <= '0;
        else if (frame_start && !hold_full && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
module tb_i2s_dac_tx;

    localparam int BH   = 8;
    localparam int SB   = 32;
    localparam int DW   = 16;
    localparam int HOLD = 1;
    localparam int FR   = 2 * BH * 2 * SB;

    logic        clk_50m = 1'b0;
    logic        rst     = 1'b1;
    logic [15:0] s_data  = '0;
    logic        s_valid = 1'b0;
    logic        s_ready, bclk, lrck, dacdat, underrun;
    logic [15:0] cur_sample;
`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    always #10 clk_50m = ~clk_50m;

    i2s_dac_tx #(
        .DATA_W        (DW),
        .BCLK_HALF     (BH),
        .SLOT_BITS     (SB),
        .UNDERRUN_HOLD (HOLD)
    ) dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .bclk         (bclk),
        .lrck         (lrck),
        .dacdat       (dacdat),
        .cur_sample   (cur_sample),
        .underrun     (underrun)
`ifdef I2S_UNDERRUN_CNT_EN
       ,.underrun_cnt (underrun_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: cycles since reset, pending-sample queue, frame sample
    int          t = 0;
    logic [15:0] m_hold[$];
    logic [15:0] m_cur = '0;
    logic        m_und = 1'b0;
    int          m_ucnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic v, input logic [15:0] d);
        logic acc;
        int   f, bc, pos;
        logic e_dat, e_lr;
        s_valid = v;
        s_data  = d;
        @(posedge clk_50m);
        if (rst) begin
            t = 0;
            m_hold.delete();
            m_cur  = '0;
            m_und  = 1'b0;
            m_ucnt = 0;
        end else begin
            acc   = v && (m_hold.size() == 0);
            t++;
            m_und = 1'b0;
            if (t % FR == 2 * BH) begin
                if (m_hold.size() > 0) begin
                    m_cur = m_hold.pop_front();
                end else begin
                    m_und = 1'b1;
                    if (HOLD == 0) m_cur = '0;
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end
            if (acc) m_hold.push_back(d);
        end
        #1;
        f     = t / (2 * BH);
        e_lr  = 1'b0;
        e_dat = 1'b0;
        if (f > 0) begin
            bc   = (2 * SB - 1 + f) % (2 * SB);
            pos  = bc % SB;
            e_lr = (bc >= SB);
            if (pos >= 1 && pos <= DW) e_dat = m_cur[DW-pos];
        end
        chk("bclk",       32'(bclk),       32'((t / BH) % 2));
        chk("lrck",       32'(lrck),       32'(e_lr));
        chk("dacdat",     32'(dacdat),     32'(e_dat));
        chk("underrun",   32'(underrun),   32'(m_und));
        chk("s_ready",    32'(s_ready),    32'(m_hold.size() == 0));
        chk("cur_sample", 32'(cur_sample), 32'(m_cur));
`ifdef I2S_UNDERRUN_CNT_EN
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
    endtask

    logic [15:0] list[5];
    int          idx;
    logic        found;

    initial begin
        rst = 1'b1;
        tick(1'b0, '0);
        tick(1'b0, '0);
        rst = 1'b0;

        // first sample ahead of the first frame start, then starve
        for (int i = 0; i < 3; i++) tick(1'b0, '0);
        tick(1'b1, 16'hA5C3);
        for (int i = 0; i < 2200; i++) tick(1'b0, '0);

        // valid held continuously: one sample per frame, in order
        list[0] = 16'h0001;
        list[1] = 16'h7FFF;
        list[2] = 16'h8000;
        list[3] = 16'($urandom);
        list[4] = 16'($urandom);
        idx = 0;
        for (int i = 0; i < 6 * FR; i++) begin
            if (idx < 5) begin
                if (m_hold.size() == 0) begin
                    tick(1'b1, list[idx]);
                    idx++;
                end else begin
                    tick(1'b1, list[idx]);
                end
            end else begin
                tick(1'b0, '0);
            end
        end

        // sparse random traffic with occasional underruns
        for (int i = 0; i < 6 * FR; i++)
            tick($urandom_range(0, 399) == 0, 16'($urandom));

        // sample offered exactly on an underrunning frame start
        found = 1'b0;
        for (int i = 0; i < 2 * FR && !found; i++) begin
            if (m_hold.size() == 0 && (t + 1) % FR == 2 * BH) begin
                tick(1'b1, 16'h1234);
                found = 1'b1;
            end else begin
                tick(1'b0, '0);
            end
        end
        chk("fs_hit", 32'(found), 32'(1));
        for (int i = 0; i < 2 * FR; i++) tick(1'b0, '0);

        // reset mid right slot with a pending sample, then empty frames
        found = 1'b0;
        for (int i = 0; i < 2 * FR && !found; i++) begin
            tick(1'b1, 16'h5A5A);
            if (t % FR == 700) found = 1'b1;
        end
        chk("mid_frame", 32'(found), 32'(1));
        rst = 1'b1;
        tick(1'b0, '0);
        rst = 1'b0;
        for (int i = 0; i < 3 * FR + 100; i++) tick(1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
